// File: rtl/psum_acc_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulation sequencer:
// FSM state encoding and the fixed adder-tree latency.
package psum_acc_ctrl_pkg;

  localparam int ADD_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/psum_tag_pipe.sv
// Stall-gated shift register carrying {valid, first, last} alongside the adder tree.
// Only the tag taps the sequencer consumes are kept; valid is exposed per stage for drain detection.
module psum_tag_pipe #(
  parameter int DEPTH = psum_acc_ctrl_pkg::ADD_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  output logic [DEPTH-1:0] valid,
  output logic             rd_first,
  output logic             zero_first,
  output logic             out_last
);

  // first is needed up to the zero-select stage, last up to the output stage
  logic [DEPTH-2:0] first_q;
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (!stall) begin
      valid   <= {valid[DEPTH-2:0], in_valid};
      first_q <= {first_q[DEPTH-3:0], in_first};
      last_q  <= {last_q[DEPTH-2:0], in_last};
    end
  end

  assign rd_first   = first_q[0];
  assign zero_first = first_q[DEPTH-2];
  assign out_last   = last_q[DEPTH-1];

endmodule

// File: rtl/psum_acc_ctrl.sv
// Multi-pass partial-sum sequencer: counts PE beats per pass and drives FIFO read/zero/write
// and final-output strobes aligned to the 3-cycle adder tree; stall freezes everything.
module psum_acc_ctrl #(
  parameter int PIX_W   = 12,
  parameter int PASS_W  = 8,
  parameter int ADD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              start,
  input  logic [PIX_W-1:0]  cfg_pix,
  input  logic [PASS_W-1:0] cfg_pass,
  input  logic              pe_valid,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              fifo_zero,
  output logic              fifo_wr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import psum_acc_ctrl_pkg::*;

  state_t              state;
  logic [PIX_W-1:0]    pix_cnt;
  logic [PIX_W-1:0]    pix_end;
  logic [PASS_W-1:0]   pass_cnt;
  logic [PASS_W-1:0]   pass_end;
  logic                accept;
  logic                beat_first;
  logic                beat_last;
  logic                pix_wrap;
  logic                cfg_ok;
  logic [ADD_LAT-1:0]  stg_valid;
  logic                rd_first;
  logic                zero_first;
  logic                out_last;

  assign accept     = (state == RUN) && pe_valid && !stall;
  assign beat_first = (pass_cnt == '0);
  assign beat_last  = (pass_cnt == pass_end);
  assign pix_wrap   = (pix_cnt == pix_end);
  assign cfg_ok     = (cfg_pix != '0) && (cfg_pass != '0);

  psum_tag_pipe #(.DEPTH(ADD_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .in_valid   (accept),
    .in_first   (beat_first),
    .in_last    (beat_last),
    .valid      (stg_valid),
    .rd_first   (rd_first),
    .zero_first (zero_first),
    .out_last   (out_last)
  );

  // Strobes are qualified by stall so a frozen stage never issues a second read or write.
  assign fifo_rd   = stg_valid[0] && !rd_first && !stall;
  assign fifo_zero = stg_valid[ADD_LAT-2] && zero_first;
  assign fifo_wr   = stg_valid[ADD_LAT-1] && !out_last && !stall;
  assign out_valid = stg_valid[ADD_LAT-1] && out_last && !stall;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      pix_end  <= '0;
      pass_cnt <= '0;
      pass_end <= '0;
      err      <= 1'b0;
    end else if (!stall) begin
      if (fifo_rd && fifo_empty)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              pix_end  <= cfg_pix - PIX_W'(1);
              pass_end <= cfg_pass - PASS_W'(1);
              pix_cnt  <= '0;
              pass_cnt <= '0;
              err      <= 1'b0;
              state    <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pe_valid) begin
            if (pix_wrap) begin
              pix_cnt  <= '0;
              pass_cnt <= pass_cnt + PASS_W'(1);
              if (beat_last)
                state <= DRAIN;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        // The output stage empties on this same edge, saving a cycle of drain.
        DRAIN: begin
          if (stg_valid[ADD_LAT-2:0] == '0)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psum_acc_ctrl.md
Name: psum_acc_ctrl

Overview:
Sequencer for the 3-stage partial-sum adder tree and its psum FIFO. It runs a multi-pass accumulation: each pass delivers cfg_pix PE beats. The first pass adds zero instead of FIFO data. Middle passes read old partial sums from the FIFO and write new ones back. The last pass sends results downstream. It tracks in-flight beats through the adder latency, honours the shared stall, and signals done once the pipeline has drained.

Parameters:
PIX_W, 12, width of cfg_pix and the pixel counter
PASS_W, 8, width of cfg_pass and the pass counter
ADD_LAT, 3, adder tree latency from PE input sample to registered out; fixed at 3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  shared pipeline stall; same signal drives the adder tree
start  in  1  one-cycle job start pulse
cfg_pix  in  PIX_W  beats per pass; sampled on accepted start
cfg_pass  in  PASS_W  number of passes; sampled on accepted start
pe_valid  in  1  PE outputs valid this cycle
fifo_empty  in  1  psum FIFO empty
fifo_rd  out  1  FIFO read strobe; data is valid on the next cycle (registered read)
fifo_zero  out  1  forces the adder fifo_data input to 0 (first pass)
fifo_wr  out  1  write adder out into the psum FIFO
out_valid  out  1  adder out is a final result
busy  out  1  job active (RUN or DRAIN)
done  out  1  one-cycle pulse when the job has fully drained
err  out  1  sticky error: bad config or FIFO underflow; cleared by an accepted start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, stage valid/flag pipes 0. Reset is asynchronous and may occur mid-job; the job is abandoned and no done pulse is produced.
- Stall: when stall=1, every register holds. fifo_rd, fifo_wr and out_valid are forced to 0. pe_valid is not accepted.
- Accepted beat: state RUN, pe_valid=1 and stall=0.
- FSM:
  - IDLE: start=1 with cfg_pix!=0 and cfg_pass!=0 latches the config, clears counters and err, and goes to RUN. start with any zero field sets err and stays in IDLE.
  - RUN: each accepted beat increments pix_cnt. When pix_cnt reaches cfg_pix-1 it wraps to 0 and pass_cnt increments. The accepted beat with pix_cnt=cfg_pix-1 and pass_cnt=cfg_pass-1 moves the FSM to DRAIN.
  - DRAIN: waits until all stage valids are 0, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start while busy is ignored. pe_valid in IDLE, DRAIN or DONE is ignored.
- Tags: each accepted beat enters a valid pipe v0→v1→v2 that advances only when stall=0. Two tags travel with it:
  - first = (pass_cnt==0)
  - last = (pass_cnt==cfg_pass-1)
- Output timing, for a beat sampled at cycle t with no stall:
  - t+1 (stage v1): fifo_rd=1 if !first.
  - t+2 (stage v2): fifo_zero=1 if first.
  - t+3: fifo_wr=1 if !last; out_valid=1 if last. These are registered and aligned with adder out.
- Single-pass job (cfg_pass=1): every beat is both first and last. No FIFO traffic at all.
- Underflow: fifo_rd asserted while fifo_empty=1 sets err. The read strobe is still issued.
- fifo_zero is a level only meaningful while v2=1; it is 0 otherwise.
- Counter widths are exact. cfg_pix=2^PIX_W-1 must wrap correctly without overflow.
- Latency from the last accepted beat to done: 4 cycles with no stall. Each stall cycle adds one.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, DRAIN, DONE) and the ADD_LAT constant, also used by the FIFO depth check.
- One natural sub-module, psum_tag_pipe: a stall-gated shift register of {valid, first, last}, depth ADD_LAT.
- Counters and FSM stay in the top module.

Test Plan:
- cfg_pix=4, cfg_pass=1, 4 back-to-back beats → fifo_zero high at t+2 for each beat; 4 out_valid pulses at t+3; fifo_rd and fifo_wr never asserted; done 4 cycles after the last beat.
- cfg_pix=3, cfg_pass=3, continuous beats → pass 0: 3 fifo_wr and 3 fifo_zero; pass 1: 3 fifo_rd and 3 fifo_wr; pass 2: 3 fifo_rd and 3 out_valid; done once.
- Same job with stall=1 for 2 cycles mid-pass 1 → strobes shift by 2 cycles, no strobe during stall, counts unchanged, done delayed by 2.
- start with cfg_pass=0 → err=1, busy stays 0; a later valid start → err cleared, busy=1.
- Pass 1 with fifo_empty=1 at a fifo_rd cycle → err=1 sticky; job still completes with done.
- rst_n low during RUN → all outputs 0 immediately; after release, no done pulse and FSM in IDLE.
